seg_write_back: RTL
===================

SEG_WRITE_BACK -- requirements
Module: seg_write_back

Interface
REQ-001 Parameter LEN, default 32: data and PC width.
REQ-002 Parameter NB_ADDR, default 5: register-file address width.
REQ-003 Parameter NB_CTRL_WB, default 2: write-back control bus width, [RegWrite, MemtoReg].
REQ-004 Parameter NB_LOAD, default 3: load-control width, [LB, LH, Unsigned].
REQ-005 Port i_clk, input, 1: sole clock, rising edge.
REQ-006 Port i_rst, input, 1: reset, synchronous and active-high.
REQ-007 Port i_valid, input, 1: MEM stage presents a real instruction.
REQ-008 Port i_stall, input, 1: hold the MEM/WB register.
REQ-009 Port i_flush, input, 1: load a bubble into the MEM/WB register.
REQ-010 Port i_ctrl_wb_bus, input, NB_CTRL_WB: [RegWrite, MemtoReg].
REQ-011 Port i_load_ctrl, input, NB_LOAD: [LB, LH, Unsigned].
REQ-012 Port i_link, input, 1: JAL/JALR; write the link address.
REQ-013 Port i_byte_offset, input, 2: data address bits [1:0].
REQ-014 Port i_read_data, input, LEN: data-memory read word.
REQ-015 Port i_alu_result, input, LEN: ALU result.
REQ-016 Port i_pc_link, input, LEN: link address, PC+8.
REQ-017 Port i_write_reg, input, NB_ADDR: destination register.
REQ-018 Port o_RegWrite, output, 1: register-file write enable, driving decode i_RegWrite.
REQ-019 Port o_write_reg, output, NB_ADDR: register-file write address.
REQ-020 Port o_write_data, output, LEN: register-file write data.
REQ-021 Port o_wb_valid, output, 1: the registered stage holds a valid instruction.
REQ-022 Port o_retired, output, LEN: count of committed instructions.

Function
REQ-023 On each rising i_clk edge, priority is i_rst, then i_flush, then i_stall, then capture.
REQ-024 Flush: clear the registered valid flag, control and load fields; zero the data fields.
REQ-025 Stall without flush: all registered fields hold their values.
REQ-026 Capture: register every i_* field listed in REQ-007 and REQ-010 to REQ-017.
REQ-027 Latency: exactly one cycle from input capture to o_RegWrite, o_write_reg and o_write_data.
REQ-028 Outputs are combinational from registered fields only, with no input-to-output combinational path.
REQ-029 o_RegWrite = valid AND RegWrite AND (write_reg != 0); register 0 is never written.
REQ-030 o_write_data selection priority: link gives pc_link; else MemtoReg gives the load-extracted value; else alu_result.
REQ-031 Load extraction is little-endian.
REQ-032 LB selects byte read_data[8*off+7 : 8*off].
REQ-033 LH selects the halfword at off[1] (0 gives [15:0], 1 gives [31:16]); off[0] is ignored.
REQ-034 With neither LB nor LH set, the full word is used.
REQ-035 The extracted byte or halfword is sign-extended when Unsigned=0 and zero-extended when Unsigned=1.
REQ-036 If LB and LH are both set, LB takes precedence.
REQ-037 o_write_reg equals the registered write_reg whenever valid, and is 0 when not valid.
REQ-038 o_wb_valid equals the registered valid flag.
REQ-039 o_retired increments by 1 on each clock edge where o_wb_valid=1 and i_stall=0, even when a flush is loading the stage on that edge.
REQ-040 o_retired wraps from 2^LEN-1 to 0.
REQ-041 During a stall, a held instruction is counted only once, on the edge where the stall releases.

Reset
REQ-042 While i_rst=1 at a clock edge, the stage is cleared: valid=0, control=0, data=0, and o_retired=0.
REQ-043 The first clock edge with i_rst=0 captures normally; i_rst asserted mid-stall or mid-flush overrides both.
REQ-044 After reset, o_RegWrite=0, o_write_reg=0, o_write_data=0, o_wb_valid=0 and o_retired=0.

Verification
REQ-045 LB, Unsigned=0, off=2, read_data=0x12_80_34_56, MemtoReg=1, reg 5 -> next cycle: o_write_data=0xFFFFFF80, o_RegWrite=1, o_write_reg=5.
REQ-046 LH, Unsigned=1, off=3, read_data=0x9ABC_1234 -> o_write_data=0x00009ABC.
REQ-047 i_link=1, pc_link=0x00000048, MemtoReg=1, write_reg=31 -> o_write_data=0x48, o_write_reg=31.
REQ-048 RegWrite=1, write_reg=0, alu_result=0xDEADBEEF -> o_RegWrite=0; o_retired still increments.
REQ-049 Valid ALU op, then i_stall held 3 cycles with changing inputs -> outputs frozen, o_retired +1 once; then stall and flush together -> bubble, o_wb_valid=0.
REQ-050 o_retired preloaded near wrap by driving 2^LEN-1 valid commits (LEN=8 build) -> reaches 0xFF, then wraps to 0x00; i_rst mid-stream -> all outputs 0 next cycle.

Source files
------------

// File: rtl/seg_write_back_if.sv
// MEM -> WB bundle: instruction fields from the MEM stage plus the
// register-file write port and retire counter produced by the WB stage.
interface seg_write_back_if #(
   parameter int LEN        = 32,
   parameter int NB_ADDR    = 5,
   parameter int NB_CTRL_WB = 2,
   parameter int NB_LOAD    = 3
);
   // Handshake: i_valid qualifies the MEM-stage fields on a rising edge;
   // i_stall holds the stage, i_flush loads a bubble and wins over i_stall.
   logic                  i_valid;
   logic                  i_stall;
   logic                  i_flush;
   logic [NB_CTRL_WB-1:0] i_ctrl_wb_bus;
   logic [NB_LOAD-1:0]    i_load_ctrl;
   logic                  i_link;
   logic [1:0]            i_byte_offset;
   logic [LEN-1:0]        i_read_data;
   logic [LEN-1:0]        i_alu_result;
   logic [LEN-1:0]        i_pc_link;
   logic [NB_ADDR-1:0]    i_write_reg;

   logic                  o_RegWrite;
   logic [NB_ADDR-1:0]    o_write_reg;
   logic [LEN-1:0]        o_write_data;
   logic                  o_wb_valid;
   logic [LEN-1:0]        o_retired;

   modport master (
      output i_valid, i_stall, i_flush, i_ctrl_wb_bus, i_load_ctrl, i_link,
             i_byte_offset, i_read_data, i_alu_result, i_pc_link, i_write_reg,
      input  o_RegWrite, o_write_reg, o_write_data, o_wb_valid, o_retired
   );

   modport slave (
      input  i_valid, i_stall, i_flush, i_ctrl_wb_bus, i_load_ctrl, i_link,
             i_byte_offset, i_read_data, i_alu_result, i_pc_link, i_write_reg,
      output o_RegWrite, o_write_reg, o_write_data, o_wb_valid, o_retired
   );
endinterface

// File: rtl/seg_write_back.sv
// MEM/WB pipeline register with load extraction, write-back mux and a
// committed-instruction counter. All outputs derive from registered state.
module seg_write_back #(
   parameter int LEN        = 32,
   parameter int NB_ADDR    = 5,
   parameter int NB_CTRL_WB = 2,
   parameter int NB_LOAD    = 3
) (
   input logic           i_clk,
   input logic           i_rst,
   seg_write_back_if.slave bus
);
   // Extraction works on at least a 32-bit view so narrow builds still elaborate.
   localparam int NB_EXT = (LEN > 32) ? LEN : 32;

   logic                  r_valid;
   logic [NB_CTRL_WB-1:0] r_ctrl_wb;
   logic [NB_LOAD-1:0]    r_load;
   logic                  r_link;
   logic [1:0]            r_byte_offset;
   logic [LEN-1:0]        r_read_data;
   logic [LEN-1:0]        r_alu_result;
   logic [LEN-1:0]        r_pc_link;
   logic [NB_ADDR-1:0]    r_write_reg;
   logic [LEN-1:0]        r_retired;

   logic [NB_EXT-1:0]     w_rd_ext;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [NB_EXT-1:0]     w_byte_ext;
   logic [NB_EXT-1:0]     w_half_ext;
   logic                  w_lb;
   logic                  w_lh;
   logic                  w_unsigned;
   logic [LEN-1:0]        w_load_val;
   logic [LEN-1:0]        w_write_data;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid       <= 1'b0;
         r_ctrl_wb     <= '0;
         r_load        <= '0;
         r_link        <= 1'b0;
         r_byte_offset <= '0;
         r_read_data   <= '0;
         r_alu_result  <= '0;
         r_pc_link     <= '0;
         r_write_reg   <= '0;
         r_retired     <= '0;
      end else begin
         // The held instruction retires on the edge that lets it leave, even if a flush follows it in.
         if (r_valid && !bus.i_stall)
            r_retired <= r_retired + {{(LEN-1){1'b0}}, 1'b1};
         if (bus.i_flush) begin
            r_valid       <= 1'b0;
            r_ctrl_wb     <= '0;
            r_load        <= '0;
            r_link        <= 1'b0;
            r_byte_offset <= '0;
            r_read_data   <= '0;
            r_alu_result  <= '0;
            r_pc_link     <= '0;
            r_write_reg   <= '0;
         end else if (!bus.i_stall) begin
            r_valid       <= bus.i_valid;
            r_ctrl_wb     <= bus.i_ctrl_wb_bus;
            r_load        <= bus.i_load_ctrl;
            r_link        <= bus.i_link;
            r_byte_offset <= bus.i_byte_offset;
            r_read_data   <= bus.i_read_data;
            r_alu_result  <= bus.i_alu_result;
            r_pc_link     <= bus.i_pc_link;
            r_write_reg   <= bus.i_write_reg;
         end
      end
   end

   assign w_lb       = r_load[2];
   assign w_lh       = r_load[1];
   assign w_unsigned = r_load[0];

   // Little-endian lanes: offset picks the byte, offset[1] picks the halfword.
   assign w_rd_ext   = NB_EXT'(r_read_data);
   assign w_byte     = w_rd_ext[{r_byte_offset, 3'b000} +: 8];
   assign w_half     = r_byte_offset[1] ? w_rd_ext[31:16] : w_rd_ext[15:0];
   assign w_byte_ext = {{(NB_EXT-8){w_byte[7] & ~w_unsigned}}, w_byte};
   assign w_half_ext = {{(NB_EXT-16){w_half[15] & ~w_unsigned}}, w_half};

   always_comb begin
      w_load_val = r_read_data;
      if (w_lb)
         w_load_val = LEN'(w_byte_ext);
      else if (w_lh)
         w_load_val = LEN'(w_half_ext);
   end

   always_comb begin
      w_write_data = r_alu_result;
      if (r_link)
         w_write_data = r_pc_link;
      else if (r_ctrl_wb[0])
         w_write_data = w_load_val;
   end

   assign bus.o_RegWrite   = r_valid & r_ctrl_wb[1] & (r_write_reg != '0);
   assign bus.o_write_reg  = r_valid ? r_write_reg : '0;
   assign bus.o_write_data = w_write_data;
   assign bus.o_wb_valid   = r_valid;
   assign bus.o_retired    = r_retired;
endmodule
